alu_result_checker: RTL and testbench

- Response-side companion to the stimulus driver of sixteen_bit_alu.
- The stimulus side pushes expected {result, zero, overflow} entries into an internal FIFO.
- ALU outputs arrive later as observations; each observation pops one expected entry and is compared against it.
- Tracks pass/fail counts, captures the first mismatch and reports run completion. Sits beside the ALU in simulation and in on-board self-test.

---
 rtl/alu_result_checker.sv | 191 +++++++++++++++++++
 tb/tb_alu_result_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// Scoreboard for sixteen_bit_alu: queues expected {result, zero, ovf} entries,
// compares them against ALU observations in order and tallies pass/fail.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                pulse: flush FIFO, clear counters/flags, enter RUN
//   check_total          observations expected in the run (sampled on start)
//   exp_*                expected-entry push side (exp_ready = FIFO not full)
//   obs_*                ALU output observation
//   pass_count           matching observations
//   fail_count           mismatching observations
//   first_fail_idx       0-based index of the first mismatch
//   first_fail_result    obs_result of the first mismatch
//   sticky_fail          any mismatch or underflow since start
//   underflow_err        observation arrived with the FIFO empty
//   busy, done           state == RUN / state == DONE (registered)
module alu_result_checker #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      check_total,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [WIDTH-1:0] exp_result,
    input  logic             exp_zero,
    input  logic             exp_ovf,
    input  logic             exp_ovf_care,
    input  logic             obs_valid,
    input  logic [WIDTH-1:0] obs_result,
    input  logic             obs_zero,
    input  logic             obs_ovf,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH-1:0] first_fail_result,
    output logic             sticky_fail,
    output logic             underflow_err,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             care;
    } entry_t;

    state_t state, state_n;

    entry_t mem [DEPTH];
    entry_t head;

    // Extra MSB on each pointer separates full from empty at wrap.
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] ptr_one;

    logic        full, empty;
    logic        in_run;
    logic        push, pop, under;
    logic        match;

    logic [15:0] obs_seen;
    logic [15:0] total_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ptr_one = {{AW{1'b0}}, 1'b1};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign exp_ready = !full;
    assign in_run    = (state == RUN) && !start;
    assign head      = mem[rd_ptr[AW-1:0]];

    assign pop   = obs_valid && in_run && !empty;
    assign under = obs_valid && in_run && empty;

    // A pop frees the slot the push needs, so a full FIFO still accepts
    // the push when a pop happens in the same cycle.
    assign push  = exp_valid && !start && (!full || pop);

    assign match = (obs_result == head.result) &&
                   (obs_zero == head.zero) &&
                   (!head.care || obs_ovf == head.ovf);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (start)
                    state_n = RUN;
                else if (obs_seen == total_q)
                    state_n = FIN;
            end
            FIN: if (start) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == FIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop)  rd_ptr <= rd_ptr + ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{exp_result, exp_zero,
                                     exp_ovf, exp_ovf_care};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_seen          <= '0;
            total_q           <= '0;
            pass_count        <= '0;
            fail_count        <= '0;
            first_fail_idx    <= '0;
            first_fail_result <= '0;
            sticky_fail       <= 1'b0;
            underflow_err     <= 1'b0;
        end else if (start) begin
            obs_seen          <= '0;
            total_q           <= check_total;
            pass_count        <= '0;
            fail_count        <= '0;
            first_fail_idx    <= '0;
            first_fail_result <= '0;
            sticky_fail       <= 1'b0;
            underflow_err     <= 1'b0;
        end else begin
            if (pop || under)
                obs_seen <= sat_inc(obs_seen);
            if (under) begin
                underflow_err <= 1'b1;
                sticky_fail   <= 1'b1;
            end
            if (pop) begin
                if (match) begin
                    pass_count <= sat_inc(pass_count);
                end else begin
                    fail_count <= sat_inc(fail_count);
                    // fail_count never returns to zero before start,
                    // so this captures only the first mismatch.
                    if (fail_count == 16'd0) begin
                        first_fail_idx    <= obs_seen;
                        first_fail_result <= obs_result;
                        sticky_fail       <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed-vector bench for alu_result_checker.
// Each scenario task drives stimulus and checks outputs inline.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] check_total = '0;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [15:0] exp_result = '0;
    logic        exp_zero = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_ovf_care = 1'b0;
    logic        obs_valid = 1'b0;
    logic [15:0] obs_result = '0;
    logic        obs_zero = 1'b0;
    logic        obs_ovf = 1'b0;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic [15:0] first_fail_idx;
    logic [15:0] first_fail_result;
    logic        sticky_fail;
    logic        underflow_err;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    alu_result_checker #(.DEPTH(8), .WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .check_total(check_total),
        .exp_valid(exp_valid),
        .exp_ready(exp_ready),
        .exp_result(exp_result),
        .exp_zero(exp_zero),
        .exp_ovf(exp_ovf),
        .exp_ovf_care(exp_ovf_care),
        .obs_valid(obs_valid),
        .obs_result(obs_result),
        .obs_zero(obs_zero),
        .obs_ovf(obs_ovf),
        .pass_count(pass_count),
        .fail_count(fail_count),
        .first_fail_idx(first_fail_idx),
        .first_fail_result(first_fail_result),
        .sticky_fail(sticky_fail),
        .underflow_err(underflow_err),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] total);
        start = 1'b1;
        check_total = total;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] r, input logic z,
                        input logic o, input logic c);
        exp_valid = 1'b1;
        exp_result = r;
        exp_zero = z;
        exp_ovf = o;
        exp_ovf_care = c;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic obs(input logic [15:0] r, input logic z,
                       input logic o);
        obs_valid = 1'b1;
        obs_result = r;
        obs_zero = z;
        obs_ovf = o;
        step();
        obs_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (exp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 1", exp_ready);
        end
        n_checks++;
        if ({pass_count, fail_count, first_fail_idx, first_fail_result}
            !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counts got %h %h %h %h exp 0",
                     pass_count, fail_count, first_fail_idx,
                     first_fail_result);
        end
        n_checks++;
        if ({sticky_fail, underflow_err, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b%b%b%b exp 0000",
                     sticky_fail, underflow_err, busy, done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_pass();
        pulse_start(16'd3);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy got %b exp 1", busy);
        end
        push(16'h000E, 1'b0, 1'b0, 1'b1);
        push(16'h0000, 1'b1, 1'b0, 1'b1);
        push(16'h8000, 1'b0, 1'b1, 1'b1);
        obs(16'h000E, 1'b0, 1'b0);
        obs(16'h0000, 1'b1, 1'b0);
        obs(16'h8000, 1'b0, 1'b1);
        n_checks++;
        if (pass_count !== 16'd3 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t1_counts got %0d/%0d exp 3/0",
                     pass_count, fail_count);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_early_done got d%b b%b exp d0 b1",
                     done, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done got d%b b%b exp d1 b0", done, busy);
        end
        n_checks++;
        if (sticky_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_sticky got %b exp 0", sticky_fail);
        end
    endtask

    task automatic test_mismatch();
        pulse_start(16'd2);
        push(16'h0007, 1'b0, 1'b0, 1'b1);
        push(16'h0001, 1'b0, 1'b0, 1'b1);
        obs(16'h0007, 1'b0, 1'b0);
        n_checks++;
        if (sticky_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_sticky_early got %b exp 0", sticky_fail);
        end
        obs(16'h0003, 1'b0, 1'b0);
        n_checks++;
        if (pass_count !== 16'd1 || fail_count !== 16'd1) begin
            n_fail++;
            $display("FAIL t2_counts got %0d/%0d exp 1/1",
                     pass_count, fail_count);
        end
        n_checks++;
        if (first_fail_idx !== 16'd1 ||
            first_fail_result !== 16'h0003) begin
            n_fail++;
            $display("FAIL t2_capture got idx %0d res %h exp 1 0003",
                     first_fail_idx, first_fail_result);
        end
        n_checks++;
        if (sticky_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_sticky got %b exp 1", sticky_fail);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_done got %b exp 1", done);
        end
    endtask

    task automatic test_ovf_dont_care();
        pulse_start(16'd1);
        push(16'h00FF, 1'b0, 1'b0, 1'b0);
        obs(16'h00FF, 1'b0, 1'b1);
        n_checks++;
        if (pass_count !== 16'd1 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t3_counts got %0d/%0d exp 1/0",
                     pass_count, fail_count);
        end
        n_checks++;
        if (sticky_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_sticky got %b exp 0", sticky_fail);
        end
    endtask

    task automatic test_full_fifo();
        pulse_start(16'd9);
        for (int i = 0; i < 8; i++)
            push(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (exp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_full got %b exp 0", exp_ready);
        end
        // Held-off push: must not enter the FIFO.
        push(16'hDEAD, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (exp_ready !== 1'b0 || pass_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t4_holdoff got rdy %b pass %0d exp 0 0",
                     exp_ready, pass_count);
        end
        exp_valid = 1'b1;
        exp_result = 16'h0108;
        exp_zero = 1'b0;
        exp_ovf = 1'b0;
        exp_ovf_care = 1'b1;
        obs(16'h0100, 1'b0, 1'b0);
        exp_valid = 1'b0;
        n_checks++;
        if (exp_ready !== 1'b0 || pass_count !== 16'd1) begin
            n_fail++;
            $display("FAIL t4_swap got rdy %b pass %0d exp 0 1",
                     exp_ready, pass_count);
        end
        for (int i = 1; i < 9; i++)
            obs(16'h0100 + 16'(i), 1'b0, 1'b0);
        n_checks++;
        if (pass_count !== 16'd9 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t4_drain got %0d/%0d exp 9/0",
                     pass_count, fail_count);
        end
        n_checks++;
        if (exp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_empty_ready got %b exp 1", exp_ready);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_done got %b exp 1", done);
        end
    endtask

    task automatic test_underflow();
        // Stored while DONE, then flushed by start; the push in the
        // start cycle itself is discarded.
        push(16'h5555, 1'b0, 1'b0, 1'b1);
        exp_valid = 1'b1;
        exp_result = 16'h5555;
        pulse_start(16'd1);
        exp_valid = 1'b0;
        obs(16'h5555, 1'b0, 1'b0);
        n_checks++;
        if (underflow_err !== 1'b1 || sticky_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_flags got u%b s%b exp u1 s1",
                     underflow_err, sticky_fail);
        end
        n_checks++;
        if (pass_count !== 16'd0 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t5_counts got %0d/%0d exp 0/0",
                     pass_count, fail_count);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_done got %b exp 1", done);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(16'd4);
        for (int i = 0; i < 4; i++)
            push(16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b1);
        obs(16'h0A00, 1'b0, 1'b0);
        obs(16'h0A01, 1'b0, 1'b0);
        n_checks++;
        if (pass_count !== 16'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_pre got pass %0d busy %b exp 2 1",
                     pass_count, busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pass_count, fail_count, first_fail_idx} !== 48'd0 ||
            {sticky_fail, underflow_err, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL t6_async got p%0d f%0d b%b d%b exp all 0",
                     pass_count, fail_count, busy, done);
        end
        n_checks++;
        if (exp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_ready got %b exp 1", exp_ready);
        end
        #2;
        rst_n = 1'b1;
        step();
        // Observation in IDLE is ignored.
        obs(16'h0A02, 1'b0, 1'b0);
        n_checks++;
        if (pass_count !== 16'd0 || underflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_idle_obs got p%0d u%b exp 0 0",
                     pass_count, underflow_err);
        end
        pulse_start(16'd1);
        push(16'h0042, 1'b0, 1'b0, 1'b1);
        obs(16'h0042, 1'b0, 1'b0);
        n_checks++;
        if (pass_count !== 16'd1 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t6_rerun got %0d/%0d exp 1/0",
                     pass_count, fail_count);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_done got %b exp 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_mismatch();
        test_ovf_dont_care();
        test_full_fifo();
        test_underflow();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
